// File: rtl/bin_a_lcd_digitos.sv
// Binary-to-decimal converter (double dabble) that emits one LCD data word {RS=1, ASCII} per digit.
// Optional leading-zero blanking is selected by defining the macro BLANK_ZEROS_EN.
module bin_a_lcd_digitos #(
    parameter int ANCHO   = 9,
    parameter int DIGITOS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ANCHO-1:0]       valor,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [9*DIGITOS-1:0]   digitos_lcd
);

    // Decimal digits needed to hold the largest ANCHO-bit value (2^bits - 1).
    function automatic int dec_digits(input int bits);
        int lim;
        int n;
        lim = (1 << bits) - 1;
        n   = 0;
        do begin
            n++;
            lim = lim / 10;
        end while (lim > 0);
        return n;
    endfunction

    localparam int BCD_NIB = dec_digits(ANCHO);
    localparam int BCD_W   = 4 * BCD_NIB;
    localparam int PAD_NIB = (BCD_NIB > DIGITOS) ? BCD_NIB : DIGITOS;
    localparam int PAD_W   = 4 * PAD_NIB;
    localparam int LIMITE  = 10**DIGITOS - 1;
    localparam int CNT_W   = $clog2(ANCHO + 1);

    localparam logic [8:0] LCD_CERO    = 9'h130;
    localparam logic [8:0] LCD_GUION   = 9'h12D;
    localparam logic [8:0] LCD_ESPACIO = 9'h120;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } estado_t;

    estado_t              estado;
    logic [ANCHO-1:0]     valor_reg;
    logic [BCD_W-1:0]     bcd;
    logic [CNT_W-1:0]     cuenta;
    logic                 ovf_pend;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_sig;
    logic [PAD_W-1:0]     bcd_pad;
    logic [9*DIGITOS-1:0] palabras;

    // One double-dabble step: correct every nibble >= 5, then shift in the next value bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        bcd_adj = bcd;
        for (int i = 0; i < BCD_NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_sig = {bcd_adj[BCD_W-2:0], valor_reg[ANCHO-1]};
    end

    // Map the finished BCD value to LCD words; digits beyond the scratch width read as zero.
    always_comb begin
        bcd_pad  = PAD_W'(bcd);
        palabras = '0;
        for (int k = 0; k < DIGITOS; k++) begin
            palabras[9*k +: 9] = LCD_CERO + 9'(bcd_pad[4*k +: 4]);
        end
`ifdef BLANK_ZEROS_EN
        begin : blanking
            logic visto;
            visto = 1'b0;
            for (int k = DIGITOS - 1; k >= 1; k--) begin
                if (bcd_pad[4*k +: 4] != 4'd0) begin
                    visto = 1'b1;
                end
                if (!visto) begin
                    palabras[9*k +: 9] = LCD_ESPACIO;
                end
            end
        end
`endif
        if (ovf_pend) begin
            palabras = {DIGITOS{LCD_GUION}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            digitos_lcd <= {DIGITOS{LCD_CERO}};
            valor_reg   <= '0;
            bcd         <= '0;
            cuenta      <= '0;
            ovf_pend    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                IDLE: begin
                    if (start) begin
                        valor_reg <= valor;
                        bcd       <= '0;
                        cuenta    <= CNT_W'(ANCHO);
                        ovf_pend  <= (int'(valor) > LIMITE);
                        estado    <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    // The cycle with cuenta == 0 is a settle cycle that sets the ANCHO+2 latency.
                    if (cuenta != '0) begin
                        bcd       <= bcd_sig;
                        valor_reg <= {valor_reg[ANCHO-2:0], 1'b0};
                        cuenta    <= cuenta - 1'b1;
                    end else begin
                        estado <= FIN;
                    end
                end
                FIN: begin
                    digitos_lcd <= palabras;
                    overflow    <= ovf_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    estado      <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_a_lcd_digitos.sv
// Bench for bin_a_lcd_digitos: a 3-digit and a 2-digit instance checked every cycle against
// an arithmetic model of the conversion, plus hand-computed result and latency checks.
module tb_bin_a_lcd_digitos;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [8:0]  valor0 = '0;
    logic [8:0]  valor1 = '0;
    logic        busy0, done0, ovf0;
    logic        busy1, done1, ovf1;
    logic [26:0] lcd0;
    logic [17:0] lcd1;

`ifdef BLANK_ZEROS_EN
    localparam logic [8:0] LZ = 9'h120;
`else
    localparam logic [8:0] LZ = 9'h130;
`endif

    bin_a_lcd_digitos #(.ANCHO(9), .DIGITOS(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .valor(valor0),
        .busy(busy0), .done(done0), .overflow(ovf0), .digitos_lcd(lcd0)
    );

    bin_a_lcd_digitos #(.ANCHO(9), .DIGITOS(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .valor(valor1),
        .busy(busy1), .done(done1), .overflow(ovf1), .digitos_lcd(lcd1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          nd[2] = '{3, 2};
    bit          m_pend[2];
    int          m_acc[2];
    int          m_cap[2];
    logic        m_busy[2];
    logic        m_done[2];
    logic        m_ovf[2];
    logic [44:0] m_words[2];
    int          cyc = 0;
    bit          cmp_en = 1'b0;

    function automatic logic [44:0] zero_words(input int n);
        logic [44:0] w = '0;
        for (int k = 0; k < n; k++) w[9*k +: 9] = 9'h130;
        return w;
    endfunction

    function automatic logic [44:0] exp_words(input int v, input int n);
        logic [44:0] w = '0;
        int x = v;
        if (v > 10**n - 1) begin
            for (int k = 0; k < n; k++) w[9*k +: 9] = 9'h12D;
            return w;
        end
        for (int k = 0; k < n; k++) begin
            w[9*k +: 9] = 9'h130 + 9'(x % 10);
            x = x / 10;
`ifdef BLANK_ZEROS_EN
            if (k > 0 && v < 10**k) w[9*k +: 9] = 9'h120;
`endif
        end
        return w;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic s;
            int   v;
            s = (i == 0) ? start0 : start1;
            v = (i == 0) ? int'(valor0) : int'(valor1);
            if (rst) begin
                m_pend[i]  = 1'b0;
                m_busy[i]  = 1'b0;
                m_done[i]  = 1'b0;
                m_ovf[i]   = 1'b0;
                m_words[i] = zero_words(nd[i]);
            end else begin
                m_done[i] = 1'b0;
                if (m_pend[i] && cyc == m_acc[i] + 11) begin
                    m_pend[i]  = 1'b0;
                    m_done[i]  = 1'b1;
                    m_ovf[i]   = (m_cap[i] > 10**nd[i] - 1);
                    m_words[i] = exp_words(m_cap[i], nd[i]);
                end else if (!m_pend[i] && s) begin
                    m_pend[i] = 1'b1;
                    m_acc[i]  = cyc;
                    m_cap[i]  = v;
                end
                m_busy[i] = m_pend[i] && cyc >= m_acc[i] + 1 && cyc <= m_acc[i] + 10;
            end
        end
        if (rst) cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy0", 64'(busy0), 64'(m_busy[0]));
            check("done0", 64'(done0), 64'(m_done[0]));
            check("ovf0",  64'(ovf0),  64'(m_ovf[0]));
            check("lcd0",  64'(lcd0),  64'(m_words[0][26:0]));
            check("busy1", 64'(busy1), 64'(m_busy[1]));
            check("done1", 64'(done1), 64'(m_done[1]));
            check("ovf1",  64'(ovf1),  64'(m_ovf[1]));
            check("lcd1",  64'(lcd1),  64'(m_words[1][17:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic conv(input int i, input int v);
        int lat;
        @(negedge clk);
        if (i == 0) begin start0 = 1'b1; valor0 = 9'(v); end
        else        begin start1 = 1'b1; valor1 = 9'(v); end
        @(posedge clk); #1;
        // Scramble valor right after capture; the result must not change.
        if (i == 0) begin start0 = 1'b0; valor0 = ~9'(v); end
        else        begin start1 = 1'b0; valor1 = ~9'(v); end
        lat = 0;
        while (((i == 0) ? done0 : done1) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency%0d_v%0d", i, v), 64'(lat), 64'd11);
    endtask

    initial begin
        int ndone;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lcd0", 64'(lcd0), 64'({9'h130, 9'h130, 9'h130}));
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_ovf0", 64'(ovf0), 64'd0);
        rst = 1'b0;

        conv(0, 47);
        check("v47", 64'(lcd0), 64'({LZ, 9'h134, 9'h137}));
        check("v47_ovf", 64'(ovf0), 64'd0);
        conv(0, 511);
        check("v511", 64'(lcd0), 64'({9'h135, 9'h131, 9'h131}));
        conv(0, 0);
        check("v0", 64'(lcd0), 64'({LZ, LZ, 9'h130}));
        conv(0, 5);
        check("v5", 64'(lcd0), 64'({LZ, LZ, 9'h135}));
        conv(0, 60);
        check("v60", 64'(lcd0), 64'({LZ, 9'h136, 9'h130}));
        conv(0, 100);
        check("v100", 64'(lcd0), 64'({9'h131, 9'h130, 9'h130}));

        conv(1, 123);
        check("d2_v123", 64'(lcd1), 64'({9'h12D, 9'h12D}));
        check("d2_v123_ovf", 64'(ovf1), 64'd1);
        conv(1, 99);
        check("d2_v99", 64'(lcd1), 64'({9'h139, 9'h139}));
        check("d2_v99_ovf", 64'(ovf1), 64'd0);
        conv(1, 100);
        check("d2_v100_ovf", 64'(ovf1), 64'd1);
        conv(1, 7);
        check("d2_v7", 64'(lcd1), 64'({LZ, 9'h137}));

        // start re-asserted on edges 3 and 5 of a conversion must be dropped
        @(negedge clk); start0 = 1'b1; valor0 = 9'd200;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1; start0 = 1'b1; valor0 = 9'd33;
        @(posedge clk); #1; start0 = 1'b0;
        @(posedge clk); #1; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        check("ignored_start_dones", 64'(ndone), 64'd1);
        check("v200", 64'(lcd0), 64'({9'h132, 9'h130, 9'h130}));

        // reset on edge 4 of a conversion of 300 aborts it
        @(negedge clk); start0 = 1'b1; valor0 = 9'd300;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        check("abort_dones", 64'(ndone), 64'd0);
        check("abort_lcd0", 64'(lcd0), 64'({9'h130, 9'h130, 9'h130}));
        conv(0, 25);
        check("v25", 64'(lcd0), 64'({LZ, 9'h132, 9'h135}));

        // reset and start together: reset wins, nothing is accepted
        @(negedge clk); rst = 1'b1; start0 = 1'b1; valor0 = 9'd7;
        @(posedge clk); #1; rst = 1'b0; start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_busy", 64'(busy0), 64'd0);
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        check("rst_start_dones", 64'(ndone), 64'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_a_lcd_digitos.md
BIN_A_LCD_DIGITOS -- requirements
Module: bin_a_lcd_digitos

Interface
REQ-001 Parameter ANCHO, default 9: width of the binary input value; legal range 4..16.
REQ-002 Parameter DIGITOS, default 3: number of decimal digits produced; legal range 1..5.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 valor  input  ANCHO  unsigned binary value; captured on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when results update.
REQ-009 overflow  output  1  high when the last converted value exceeded 10^DIGITOS-1.
REQ-010 digitos_lcd  output  9*DIGITOS  LCD write words, one per digit; digit 0 (units) at bits [8:0], digit k at [9k+8:9k].

Function
REQ-011 Each word SHALL be {RS=1, ASCII}: a digit d SHALL be encoded as 9'h130+d.
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and FIN.
REQ-013 IDLE with start=1: capture valor, clear the BCD scratch, set the shift count to ANCHO, go to SHIFT, and assert busy from the next cycle.
REQ-014 SHIFT: one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left one bit from the value); after ANCHO steps, go to FIN.
REQ-015 FIN: load digitos_lcd and overflow, pulse done for exactly one cycle, deassert busy, return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle that begins ANCHO+2 rising edges after the edge that accepted start (ANCHO=9: edge 11); a new start is accepted in the cycle following done.
REQ-017 start while busy or in FIN SHALL be ignored and SHALL NOT be queued.
REQ-018 The BCD scratch width SHALL be sized so no intermediate carry is lost for the given ANCHO.
REQ-019 Overflow: if valor > 10^DIGITOS-1, set overflow=1 and drive every digit word to 9'h12D ('-'); otherwise set overflow=0.
REQ-020 digitos_lcd and overflow SHALL hold their values between FIN cycles and SHALL change only in FIN or on reset.
REQ-021 valor changes after the start edge SHALL NOT affect the conversion in progress.
REQ-022 valor=0 SHALL produce all digits 9'h130, subject to REQ-027.

Reset
REQ-023 rst=1 at a rising edge SHALL set: state IDLE, busy=0, done=0, overflow=0, every digit word 9'h130, scratch and count cleared.
REQ-024 rst during SHIFT or FIN SHALL abort the conversion: no done pulse and no output update for the aborted request.
REQ-025 rst and start high together SHALL give reset priority; start is not accepted.

Configuration
REQ-026 Macro BLANK_ZEROS_EN SHALL select leading-zero blanking.
REQ-027 With BLANK_ZEROS_EN defined: every zero digit above the most significant nonzero digit SHALL be 9'h120 (space), and the units digit SHALL always be shown; overflow output is unaffected.
REQ-028 Without BLANK_ZEROS_EN: all digits SHALL be shown, including leading zeros.

Verification
REQ-029 ANCHO=9, DIGITOS=3, valor=47, start pulse -> done on edge 11; digitos_lcd = {9'h130, 9'h134, 9'h137}; overflow=0; busy high for edges 1..10.
REQ-030 ANCHO=9, DIGITOS=3, valor=511 -> {9'h135, 9'h131, 9'h131}, overflow=0; then valor=0 -> all 9'h130 (macro off), or {9'h120, 9'h120, 9'h130} (macro on).
REQ-031 ANCHO=9, DIGITOS=2, valor=123 -> overflow=1, both words 9'h12D; a following valor=99 -> {9'h139, 9'h139}, overflow=0.
REQ-032 start re-asserted on edges 3 and 5 of a conversion of 200 -> exactly one done, result {9'h132, 9'h130, 9'h130}, no second conversion.
REQ-033 rst on edge 4 of a conversion of 300 -> no done; outputs all 9'h130; a fresh start with 25 -> {9'h130, 9'h132, 9'h135} at latency ANCHO+2.
REQ-034 BLANK_ZEROS_EN defined, valor=5 -> {9'h120, 9'h120, 9'h135}; valor=60 -> {9'h120, 9'h136, 9'h130}.
